// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the memory port and the arbiter.
// The arbiter connects through the slave modport; the environment uses the master modport.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_mask;
    logic        ls_gnt;
    logic        ls_valid;
    logic [31:0] ls_rdata;

    logic        mem_request;
    logic        mem_we_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    logic        timeout_err;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_mask, mem_valid, mem_rdata,
        output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
        output mem_request, mem_we_re, mem_addr, mem_wdata, mem_mask, timeout_err
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_mask, mem_valid, mem_rdata,
        input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
        input  mem_request, mem_we_re, mem_addr, mem_wdata, mem_mask, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction at a time,
// with LS priority bounded by a fetch starvation limit and a watchdog on stalled accesses.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyLs} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
    localparam logic [7:0] WdLast    = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [7:0]  wd_cnt_q, wd_cnt_d;
    logic        mem_request_q, mem_request_d;
    logic        mem_we_re_q, mem_we_re_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        ls_valid_q, ls_valid_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        timeout_err_q, timeout_err_d;
    logic        if_gnt, ls_gnt, pick_if, done;

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        mem_request_d = mem_request_q;
        mem_we_re_d   = mem_we_re_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_mask_d    = mem_mask_q;
        if_rdata_d    = if_rdata_q;
        ls_rdata_d    = ls_rdata_q;
        timeout_err_d = timeout_err_q;
        if_valid_d    = 1'b0;
        ls_valid_d    = 1'b0;
        if_gnt        = 1'b0;
        ls_gnt        = 1'b0;
        pick_if       = bus.if_req && (!bus.ls_req || (starve_cnt_q == StarveMax));
        // Abort fires on the last busy cycle so mem_request falls exactly TIMEOUT cycles in.
        done          = bus.mem_valid || (wd_cnt_q == WdLast);

        unique case (state_q)
            StIdle: begin
                if (bus.if_req || bus.ls_req) begin
                    mem_request_d = 1'b1;
                    wd_cnt_d      = '0;
                    if (pick_if) begin
                        if_gnt       = 1'b1;
                        state_d      = StBusyIf;
                        mem_we_re_d  = 1'b0;
                        mem_addr_d   = bus.if_addr;
                        mem_wdata_d  = '0;
                        mem_mask_d   = 4'hF;
                        starve_cnt_d = '0;
                    end else begin
                        ls_gnt      = 1'b1;
                        state_d     = StBusyLs;
                        mem_we_re_d = bus.ls_we;
                        mem_addr_d  = bus.ls_addr;
                        mem_wdata_d = bus.ls_wdata;
                        mem_mask_d  = bus.ls_mask;
                        if (bus.if_req && (starve_cnt_q < StarveMax)) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end
                end
            end
            StBusyIf, StBusyLs: begin
                if (done) begin
                    state_d       = StIdle;
                    mem_request_d = 1'b0;
                    if (!bus.mem_valid) begin
                        timeout_err_d = 1'b1;
                    end
                    if (state_q == StBusyIf) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_valid ? bus.mem_rdata : '0;
                    end else begin
                        ls_valid_d = 1'b1;
                        ls_rdata_d = bus.mem_valid ? bus.mem_rdata : '0;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            starve_cnt_q  <= '0;
            wd_cnt_q      <= '0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_mask_q    <= '0;
            if_valid_q    <= 1'b0;
            if_rdata_q    <= '0;
            ls_valid_q    <= 1'b0;
            ls_rdata_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_mask_q    <= mem_mask_d;
            if_valid_q    <= if_valid_d;
            if_rdata_q    <= if_rdata_d;
            ls_valid_q    <= ls_valid_d;
            ls_rdata_q    <= ls_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Grants are combinational, so they are masked while reset is held.
    assign bus.if_gnt      = if_gnt & ~rst;
    assign bus.ls_gnt      = ls_gnt & ~rst;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.ls_valid    = ls_valid_q;
    assign bus.ls_rdata    = ls_rdata_q;
    assign bus.mem_request = mem_request_q;
    assign bus.mem_we_re   = mem_we_re_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_mask    = mem_mask_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: lock-step stimulus per scenario, with responses
// checked against a per-requester scoreboard queue whenever a valid pulse appears.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STARVE_MAX(4),
        .TIMEOUT   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    logic [31:0] if_q[$];
    logic [31:0] ls_q[$];

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.ls_mask   = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
    endtask

    // Response scoreboard
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (bus.if_valid === 1'b1) begin
            n_vec++;
            if (if_q.size() == 0) begin
                n_miss++;
                $display("FAIL if_resp_unexpected: got if_valid=1 rdata=%h, required no pulse",
                         bus.if_rdata);
            end else begin
                exp_v = if_q.pop_front();
                if (bus.if_rdata !== exp_v) begin
                    n_miss++;
                    $display("FAIL if_resp_data: got %h, required %h", bus.if_rdata, exp_v);
                end
            end
        end
        if (bus.ls_valid === 1'b1) begin
            n_vec++;
            if (ls_q.size() == 0) begin
                n_miss++;
                $display("FAIL ls_resp_unexpected: got ls_valid=1 rdata=%h, required no pulse",
                         bus.ls_rdata);
            end else begin
                exp_v = ls_q.pop_front();
                if (bus.ls_rdata !== exp_v) begin
                    n_miss++;
                    $display("FAIL ls_resp_data: got %h, required %h", bus.ls_rdata, exp_v);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        cyc();
        cyc();
        smp();
        n_vec++;
        if ({bus.if_gnt, bus.ls_gnt} !== 2'b00) begin
            n_miss++;
            $display("FAIL reset_gnt: got %b, required 00", {bus.if_gnt, bus.ls_gnt});
        end
        n_vec++;
        if ({bus.mem_request, bus.mem_we_re, bus.mem_addr, bus.mem_wdata, bus.mem_mask,
             bus.if_valid, bus.ls_valid, bus.if_rdata, bus.ls_rdata, bus.timeout_err} !== '0) begin
            n_miss++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h mask=%h ifv=%b lsv=%b ifr=%h lsr=%h err=%b, required all 0",
                     bus.mem_request, bus.mem_we_re, bus.mem_addr, bus.mem_wdata, bus.mem_mask,
                     bus.if_valid, bus.ls_valid, bus.if_rdata, bus.ls_rdata, bus.timeout_err);
        end
        cyc();
        rst = 1'b0;
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
    endtask

    task automatic test_fetch();
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        smp();
        n_vec++;
        if ({bus.if_gnt, bus.ls_gnt} !== 2'b10) begin
            n_miss++;
            $display("FAIL fetch_gnt: got if/ls=%b, required 10", {bus.if_gnt, bus.ls_gnt});
        end
        cyc();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'hFFFF_FFFC;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        if_q.push_back(32'h0050_0093);
        smp();
        n_vec++;
        if ({bus.mem_request, bus.mem_we_re, bus.mem_mask, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
            n_miss++;
            $display("FAIL fetch_mem_fields: got req=%b we=%b mask=%h addr=%h wd=%h, required 1 0 f 00000100 00000000",
                     bus.mem_request, bus.mem_we_re, bus.mem_mask, bus.mem_addr, bus.mem_wdata);
        end
        cyc();
        bus.mem_valid = 1'b0;
        smp();
        n_vec++;
        if ({bus.if_valid, bus.mem_request} !== 2'b10) begin
            n_miss++;
            $display("FAIL fetch_resp_cycle: got valid/req=%b, required 10",
                     {bus.if_valid, bus.mem_request});
        end
        cyc();
        smp();
        n_vec++;
        if (bus.if_valid !== 1'b0 || if_q.size() != 0) begin
            n_miss++;
            $display("FAIL fetch_single_pulse: got valid=%b pending=%0d, required 0 0",
                     bus.if_valid, if_q.size());
        end
    endtask

    task automatic test_priority();
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h104;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h2000;
        bus.ls_mask = 4'hF;
        smp();
        n_vec++;
        if ({bus.if_gnt, bus.ls_gnt} !== 2'b01) begin
            n_miss++;
            $display("FAIL prio_ls_first: got if/ls=%b, required 01", {bus.if_gnt, bus.ls_gnt});
        end
        cyc();
        bus.ls_req    = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        ls_q.push_back(32'h1122_3344);
        smp();
        n_vec++;
        if ({bus.mem_request, bus.mem_we_re, bus.mem_addr, bus.if_gnt} !==
            {1'b1, 1'b0, 32'h2000, 1'b0}) begin
            n_miss++;
            $display("FAIL prio_ls_access: got req=%b we=%b addr=%h ifgnt=%b, required 1 0 00002000 0",
                     bus.mem_request, bus.mem_we_re, bus.mem_addr, bus.if_gnt);
        end
        cyc();
        bus.mem_valid = 1'b0;
        smp();
        n_vec++;
        if ({bus.ls_valid, bus.if_gnt} !== 2'b11) begin
            n_miss++;
            $display("FAIL prio_if_gnt_with_ls_valid: got lsv/ifgnt=%b, required 11",
                     {bus.ls_valid, bus.if_gnt});
        end
        cyc();
        bus.if_req    = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hAAAA_0001;
        if_q.push_back(32'hAAAA_0001);
        smp();
        n_vec++;
        if ({bus.mem_request, bus.mem_addr} !== {1'b1, 32'h104}) begin
            n_miss++;
            $display("FAIL prio_if_access: got req=%b addr=%h, required 1 00000104",
                     bus.mem_request, bus.mem_addr);
        end
        cyc();
        bus.mem_valid = 1'b0;
        smp();
        cyc();
        smp();
        n_vec++;
        if (if_q.size() != 0 || ls_q.size() != 0) begin
            n_miss++;
            $display("FAIL prio_pending: got if=%0d ls=%0d responses outstanding, required 0 0",
                     if_q.size(), ls_q.size());
        end
    endtask

    task automatic test_store();
        cyc();
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 32'h3000;
        bus.ls_wdata = 32'hDEAD_BEEF;
        bus.ls_mask  = 4'b0011;
        smp();
        n_vec++;
        if ({bus.if_gnt, bus.ls_gnt} !== 2'b01) begin
            n_miss++;
            $display("FAIL store_gnt: got if/ls=%b, required 01", {bus.if_gnt, bus.ls_gnt});
        end
        cyc();
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = 32'h5555;
        bus.ls_wdata = 32'h0;
        bus.ls_mask  = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus.mem_valid = 1'b1;
                bus.mem_rdata = 32'h0;
                ls_q.push_back(32'h0);
            end
            smp();
            n_vec++;
            if ({bus.mem_request, bus.mem_we_re, bus.mem_addr, bus.mem_wdata, bus.mem_mask} !==
                {1'b1, 1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0011}) begin
                n_miss++;
                $display("FAIL store_hold_%0d: got req=%b we=%b addr=%h wd=%h mask=%b, required 1 1 00003000 deadbeef 0011",
                         i, bus.mem_request, bus.mem_we_re, bus.mem_addr, bus.mem_wdata,
                         bus.mem_mask);
            end
            cyc();
        end
        bus.mem_valid = 1'b0;
        smp();
        n_vec++;
        if ({bus.ls_valid, bus.mem_request} !== 2'b10) begin
            n_miss++;
            $display("FAIL store_resp: got lsv/req=%b, required 10", {bus.ls_valid, bus.mem_request});
        end
        cyc();
        smp();
        n_vec++;
        if (bus.ls_valid !== 1'b0 || ls_q.size() != 0) begin
            n_miss++;
            $display("FAIL store_single_pulse: got valid=%b pending=%0d, required 0 0",
                     bus.ls_valid, ls_q.size());
        end
    endtask

    task automatic test_starve();
        logic [5:0] order = 6'b010000;  // bit k set: grant k goes to fetch
        logic [3:0] exp_starve = 4'd0;
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h4000;
        bus.ls_mask = 4'hF;
        for (int k = 0; k < 6; k++) begin
            smp();
            n_vec++;
            if ({bus.if_gnt, bus.ls_gnt} !== (order[k] ? 2'b10 : 2'b01)) begin
                n_miss++;
                $display("FAIL starve_order_%0d: got if/ls=%b, required %b", k,
                         {bus.if_gnt, bus.ls_gnt}, order[k] ? 2'b10 : 2'b01);
            end
            if (order[k]) exp_starve = 4'd0;
            else if (exp_starve < 4'd4) exp_starve = exp_starve + 4'd1;
            cyc();
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 32'h5000_0000 + 32'(k);
            if (order[k]) if_q.push_back(32'h5000_0000 + 32'(k));
            else ls_q.push_back(32'h5000_0000 + 32'(k));
            smp();
            n_vec++;
            if ({bus.if_gnt, bus.ls_gnt} !== 2'b00 || dut.starve_cnt_q !== exp_starve) begin
                n_miss++;
                $display("FAIL starve_busy_%0d: got gnt=%b starve=%0d, required 00 %0d", k,
                         {bus.if_gnt, bus.ls_gnt}, dut.starve_cnt_q, exp_starve);
            end
            cyc();
            bus.mem_valid = 1'b0;
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        smp();
        cyc();
        smp();
        n_vec++;
        if (if_q.size() != 0 || ls_q.size() != 0) begin
            n_miss++;
            $display("FAIL starve_pending: got if=%0d ls=%0d responses outstanding, required 0 0",
                     if_q.size(), ls_q.size());
        end
    endtask

    task automatic test_timeout();
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        smp();
        n_vec++;
        if (bus.if_gnt !== 1'b1) begin
            n_miss++;
            $display("FAIL wd_gnt: got %b, required 1", bus.if_gnt);
        end
        cyc();
        bus.if_req = 1'b0;
        if_q.push_back(32'h0);
        for (int i = 0; i < 8; i++) begin
            smp();
            n_vec++;
            if ({bus.mem_request, bus.timeout_err} !== 2'b10) begin
                n_miss++;
                $display("FAIL wd_busy_%0d: got req/err=%b, required 10", i,
                         {bus.mem_request, bus.timeout_err});
            end
            cyc();
        end
        smp();
        n_vec++;
        if ({bus.mem_request, bus.timeout_err, bus.if_valid} !== 3'b011) begin
            n_miss++;
            $display("FAIL wd_abort: got req/err/ifv=%b, required 011",
                     {bus.mem_request, bus.timeout_err, bus.if_valid});
        end
        cyc();
        cyc();
        smp();
        n_vec++;
        if ({bus.timeout_err, bus.if_valid} !== 2'b10) begin
            n_miss++;
            $display("FAIL wd_sticky: got err/ifv=%b, required 10", {bus.timeout_err, bus.if_valid});
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        smp();
        n_vec++;
        if (bus.timeout_err !== 1'b0) begin
            n_miss++;
            $display("FAIL wd_err_cleared: got %b, required 0", bus.timeout_err);
        end
        // Completion on the watchdog's last cycle wins over the abort.
        cyc();
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h6000;
        bus.ls_mask = 4'hF;
        smp();
        n_vec++;
        if (bus.ls_gnt !== 1'b1) begin
            n_miss++;
            $display("FAIL wd2_gnt: got %b, required 1", bus.ls_gnt);
        end
        cyc();
        bus.ls_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                bus.mem_valid = 1'b1;
                bus.mem_rdata = 32'hCAFE_F00D;
                ls_q.push_back(32'hCAFE_F00D);
            end
            smp();
            n_vec++;
            if (bus.mem_request !== 1'b1) begin
                n_miss++;
                $display("FAIL wd2_busy_%0d: got req=%b, required 1", i, bus.mem_request);
            end
            cyc();
        end
        bus.mem_valid = 1'b0;
        smp();
        n_vec++;
        if ({bus.mem_request, bus.timeout_err, bus.ls_valid} !== 3'b001) begin
            n_miss++;
            $display("FAIL wd2_complete: got req/err/lsv=%b, required 001",
                     {bus.mem_request, bus.timeout_err, bus.ls_valid});
        end
        cyc();
        smp();
        n_vec++;
        if (if_q.size() != 0 || ls_q.size() != 0) begin
            n_miss++;
            $display("FAIL wd_pending: got if=%0d ls=%0d responses outstanding, required 0 0",
                     if_q.size(), ls_q.size());
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h7000;
        bus.ls_mask = 4'hC;
        smp();
        n_vec++;
        if (bus.ls_gnt !== 1'b1) begin
            n_miss++;
            $display("FAIL rstmid_gnt: got %b, required 1", bus.ls_gnt);
        end
        cyc();
        bus.ls_req = 1'b0;
        smp();
        n_vec++;
        if (bus.mem_request !== 1'b1) begin
            n_miss++;
            $display("FAIL rstmid_busy: got req=%b, required 1", bus.mem_request);
        end
        cyc();
        rst = 1'b1;
        smp();
        cyc();
        rst           = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        smp();
        n_vec++;
        if ({bus.mem_request, bus.mem_we_re, bus.mem_addr, bus.mem_wdata, bus.mem_mask,
             bus.if_gnt, bus.ls_gnt, bus.if_valid, bus.ls_valid, bus.if_rdata, bus.ls_rdata,
             bus.timeout_err} !== '0) begin
            n_miss++;
            $display("FAIL rstmid_outputs: got req=%b we=%b addr=%h wd=%h mask=%h gnt=%b%b v=%b%b ifr=%h lsr=%h err=%b, required all 0",
                     bus.mem_request, bus.mem_we_re, bus.mem_addr, bus.mem_wdata, bus.mem_mask,
                     bus.if_gnt, bus.ls_gnt, bus.if_valid, bus.ls_valid, bus.if_rdata,
                     bus.ls_rdata, bus.timeout_err);
        end
        cyc();
        bus.mem_valid = 1'b0;
        smp();
        n_vec++;
        if ({bus.ls_valid, bus.ls_rdata} !== 33'h0) begin
            n_miss++;
            $display("FAIL rstmid_late_valid: got lsv=%b lsr=%h, required 0 00000000",
                     bus.ls_valid, bus.ls_rdata);
        end
        cyc();
        smp();
        n_vec++;
        if (if_q.size() != 0 || ls_q.size() != 0) begin
            n_miss++;
            $display("FAIL rstmid_pending: got if=%0d ls=%0d responses outstanding, required 0 0",
                     if_q.size(), ls_q.size());
        end
    endtask

    initial begin
        idle_in();
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_starve();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
